// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and its write FIFO.
package dmem_port_arbiter_pkg;

  localparam int ARB_FIFO_DEPTH = 4;
  localparam int ARB_HIGH_WATER = 3;
  localparam int ARB_LOW_WATER  = 1;
  localparam int ARB_STARVE_MAX = 8;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int PTR_W     = 2;
  localparam int LEVEL_W   = 3;
  localparam int STARVE_W  = 4;

  // Sized copies of the thresholds so comparisons stay width-matched.
  localparam logic [LEVEL_W-1:0]  LVL_FULL     = LEVEL_W'(ARB_FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0]  LVL_HIGH     = LEVEL_W'(ARB_HIGH_WATER);
  localparam logic [LEVEL_W-1:0]  LVL_LOW      = LEVEL_W'(ARB_LOW_WATER);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(ARB_STARVE_MAX);

  typedef enum logic [0:0] {
    ARB_RD_PRIO,
    ARB_WR_DRAIN
  } t_arb_state;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } t_wr_entry;

endpackage

// File: rtl/dmem_wr_fifo.sv
// Four-entry CPU write FIFO with occupancy count and youngest-match read forwarding.
module dmem_wr_fifo
  import dmem_port_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  t_wr_entry          push_entry,
  input  logic               pop,
  output t_wr_entry          head,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] next_level,
  input  logic [ADDR_W-1:0]  match_addr,
  output logic               match_hit,
  output logic [DATA_W-1:0]  match_data
);

  t_wr_entry          entries [ARB_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != LVL_FULL) || do_pop);
  assign head       = entries[rd_ptr];
  assign level      = count;
  assign next_level = count + LEVEL_W'(do_push) - LEVEL_W'(do_pop);

  // Walk oldest to youngest so the last hit wins; a same-cycle push is youngest of all.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    match_hit  = 1'b0;
    match_data = '0;
    for (int i = 0; i < ARB_FIFO_DEPTH; i++) begin
      if ((LEVEL_W'(i) < count) && (entries[rd_ptr + PTR_W'(i)].addr == match_addr)) begin
        match_hit  = 1'b1;
        match_data = entries[rd_ptr + PTR_W'(i)].data;
      end
    end
    if (push && (push_entry.addr == match_addr)) begin
      match_hit  = 1'b1;
      match_data = push_entry.data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= next_level;
    end
  end

  // NOTE: storage is deliberately not reset; the count register alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (do_push && !reset) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between buffered CPU writes and VGA reads,
// favouring reads until the write FIFO hits high water or reads starve the writes.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_wr_en,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_data,
  input  logic               vga_rd_req,
  input  logic [ADDR_W-1:0]  vga_rd_addr,
  output logic               vga_rd_gnt,
  output logic               vga_rd_valid,
  output logic [DATA_W-1:0]  vga_rd_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_wr_en,
  output logic [DATA_W-1:0]  mem_wr_data,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic [LEVEL_W-1:0] fifo_level
);

  t_arb_state          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;
  logic                push;
  logic                pop;
  logic                gnt;
  t_wr_entry           push_entry;
  t_wr_entry           head;
  logic [LEVEL_W-1:0]  level;
  logic [LEVEL_W-1:0]  next_level;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic                valid_q;
  logic                fwd_hit_q;
  logic [DATA_W-1:0]   fwd_data_q;

  assign push       = cpu_wr_en && !reset;
  assign push_entry = '{addr: cpu_addr, data: cpu_data};

  dmem_wr_fifo u_wr_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .level      (level),
    .next_level (next_level),
    .match_addr (vga_rd_addr),
    .match_hit  (fwd_hit),
    .match_data (fwd_data)
  );

  // A full FIFO always pops so that a same-cycle push can never be dropped.
  always_comb begin
    pop = 1'b0;
    gnt = 1'b0;
    if (!reset) begin
      if (state == ARB_WR_DRAIN)  pop = (level != '0);
      else if (level == LVL_FULL) pop = 1'b1;
      else if (vga_rd_req)        gnt = 1'b1;
      else                        pop = (level != '0);
    end
  end

  always_comb begin
    starve_next = starve_cnt;
    if (pop)
      starve_next = '0;
    else if (gnt && (level != '0) && (starve_cnt < STARVE_LIMIT))
      starve_next = starve_cnt + STARVE_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_RD_PRIO;
      starve_cnt <= '0;
      valid_q    <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      starve_cnt <= starve_next;
      valid_q    <= gnt;
      fwd_hit_q  <= gnt && fwd_hit;
      if (gnt) fwd_data_q <= fwd_data;
      case (state)
        ARB_RD_PRIO:
          if ((next_level >= LVL_HIGH) || (starve_next == STARVE_LIMIT)) state <= ARB_WR_DRAIN;
        ARB_WR_DRAIN:
          if (next_level <= LVL_LOW) state <= ARB_RD_PRIO;
        default:
          state <= ARB_RD_PRIO;
      endcase
    end
  end

  // Valid is masked by reset so a read granted just before reset never completes.
  assign vga_rd_valid = valid_q && !reset;
  assign vga_rd_data  = vga_rd_valid ? (fwd_hit_q ? fwd_data_q : mem_rd_data) : '0;
  assign vga_rd_gnt   = gnt;
  assign mem_wr_en    = pop;
  assign mem_addr     = pop ? head.addr : (gnt ? vga_rd_addr : '0);
  assign mem_wr_data  = pop ? head.data : '0;
  assign fifo_level   = level;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a queue-based reference model.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr_en = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_data = '0;
  logic        vga_rd_req = 1'b0;
  logic [14:0] vga_rd_addr = '0;
  logic        vga_rd_gnt;
  logic        vga_rd_valid;
  logic [15:0] vga_rd_data;
  logic [14:0] mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data = '0;
  logic [2:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .vga_rd_req   (vga_rd_req),
    .vga_rd_addr  (vga_rd_addr),
    .vga_rd_gnt   (vga_rd_gnt),
    .vga_rd_valid (vga_rd_valid),
    .vga_rd_data  (vga_rd_data),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .fifo_level   (fifo_level)
  );

  // Physical memory the DUT drives, and the golden image of what it must contain.
  logic [15:0] mem  [0:32767];
  logic [15:0] gold [0:32767];

  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  always @(posedge clock) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, arbitration from the priority/water-mark rules.
  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         q[$];
  bit          drain = 1'b0;
  int          starve = 0;
  bit          exp_valid = 1'b0;
  logic [15:0] exp_data = '0;

  always @(negedge clock) begin
    bit          e_gnt;
    bit          e_pop;
    int          cnt;
    logic [14:0] e_addr;
    logic [15:0] rv;
    wr_t         e;
    cnt   = q.size();
    e_gnt = 1'b0;
    e_pop = 1'b0;
    if (!reset) begin
      if (drain)         e_pop = (cnt > 0);
      else if (cnt >= 4) e_pop = 1'b1;
      else if (vga_rd_req) e_gnt = 1'b1;
      else               e_pop = (cnt > 0);
    end
    e_addr = e_pop ? q[0].addr : (e_gnt ? vga_rd_addr : 15'd0);

    check("gnt",      32'(vga_rd_gnt), 32'(e_gnt));
    check("wr_en",    32'(mem_wr_en),  32'(e_pop));
    check("mem_addr", 32'(mem_addr),   32'(e_addr));
    if (e_pop) check("wr_data", 32'(mem_wr_data), 32'(q[0].data));
    check("level",    32'(fifo_level), cnt);
    check("rd_valid", 32'(vga_rd_valid), 32'(exp_valid && !reset));
    if (exp_valid && !reset) check("rd_data", 32'(vga_rd_data), 32'(exp_data));
    if (reset) check("rd_data_rst", 32'(vga_rd_data), 32'd0);

    if (reset) begin
      q.delete();
      drain     = 1'b0;
      starve    = 0;
      exp_valid = 1'b0;
    end else begin
      if (e_gnt) begin
        rv = gold[vga_rd_addr];
        foreach (q[i]) if (q[i].addr == vga_rd_addr) rv = q[i].data;
        if (cpu_wr_en && (cpu_addr == vga_rd_addr)) rv = cpu_data;
        exp_data = rv;
        if (cnt > 0 && starve < 8) starve++;
      end
      exp_valid = e_gnt;
      if (e_pop) begin
        gold[q[0].addr] = q[0].data;
        void'(q.pop_front());
        starve = 0;
      end
      if (cpu_wr_en) begin
        e.addr = cpu_addr;
        e.data = cpu_data;
        q.push_back(e);
      end
      if (!drain && (q.size() >= 3 || starve >= 8)) drain = 1'b1;
      else if (drain && q.size() <= 1)              drain = 1'b0;
    end
  end

  // Drive one cycle of inputs just after the edge; return just after the following falling edge.
  task automatic drive(input logic r, input logic w, input logic [14:0] a, input logic [15:0] d,
                       input logic rq, input logic [14:0] ra);
    @(posedge clock);
    #1;
    reset       = r;
    cpu_wr_en   = w;
    cpu_addr    = a;
    cpu_data    = d;
    vga_rd_req  = rq;
    vga_rd_addr = ra;
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b0, 15'd0);
  endtask

  initial begin
    int  peak;
    bit  saw_block;
    bit  hold;
    logic rq;
    logic [14:0] ra;
    int  wr_pct;
    int  rd_pct;
    int  pct_tab [4][2] = '{'{20, 50}, '{60, 80}, '{90, 30}, '{40, 95}};

    for (int a = 0; a < 32768; a++) begin
      mem[a]  = init_val(a);
      gold[a] = init_val(a);
    end
    mem[15'h0020]  = 16'hBEEF;
    gold[15'h0020] = 16'hBEEF;

    drive(1'b1, 1'b0, 15'd0, 16'd0, 1'b0, 15'd0);
    drive(1'b1, 1'b0, 15'd0, 16'd0, 1'b0, 15'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_valid", 32'(vga_rd_valid), 32'd0);

    // Single push drains exactly one cycle later.
    drive(1'b0, 1'b1, 15'h0010, 16'h1234, 1'b0, 15'd0);
    check("push_no_bypass", 32'(mem_wr_en), 32'd0);
    check("push_level0", 32'(fifo_level), 32'd0);
    idle(1);
    check("pop_wr_en", 32'(mem_wr_en), 32'd1);
    check("pop_addr", 32'(mem_addr), 32'h0010);
    check("pop_data", 32'(mem_wr_data), 32'h1234);
    check("pop_level1", 32'(fifo_level), 32'd1);
    idle(1);
    check("after_pop_level", 32'(fifo_level), 32'd0);
    check("after_pop_wr_en", 32'(mem_wr_en), 32'd0);

    // Plain read from memory.
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0020);
    check("rd_gnt", 32'(vga_rd_gnt), 32'd1);
    check("rd_mem_addr", 32'(mem_addr), 32'h0020);
    idle(1);
    check("rd_valid", 32'(vga_rd_valid), 32'd1);
    check("rd_data_beef", 32'(vga_rd_data), 32'hBEEF);

    // Youngest queued write is forwarded.
    drive(1'b0, 1'b1, 15'h0030, 16'h1111, 1'b1, 15'h0040);
    drive(1'b0, 1'b1, 15'h0030, 16'h2222, 1'b1, 15'h0040);
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0030);
    check("fwd_gnt", 32'(vga_rd_gnt), 32'd1);
    check("fwd_level", 32'(fifo_level), 32'd2);
    idle(1);
    check("fwd_valid", 32'(vga_rd_valid), 32'd1);
    check("fwd_data", 32'(vga_rd_data), 32'h2222);
    idle(2);

    // Eight starving grants force one write drain.
    drive(1'b0, 1'b1, 15'h0050, 16'hAAAA, 1'b1, 15'h0060);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0060);
      check("starve_gnt", 32'(vga_rd_gnt), 32'd1);
      check("starve_level", 32'(fifo_level), 32'd1);
    end
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0060);
    check("starve_block", 32'(vga_rd_gnt), 32'd0);
    check("starve_pop", 32'(mem_wr_en), 32'd1);
    check("starve_pop_addr", 32'(mem_addr), 32'h0050);
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0060);
    check("starve_regrant", 32'(vga_rd_gnt), 32'd1);
    idle(1);

    // Continuous writes against constant reads: high water then low water.
    peak = 0;
    saw_block = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 15'(15'h0100 + i), 16'($urandom), 1'b1, 15'h0070);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (!vga_rd_gnt) saw_block = 1'b1;
    end
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0070);
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0070);
    drive(1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 15'h0070);
    check("hw_peak", 32'(peak), 32'd3);
    check("hw_blocked", 32'(saw_block), 32'd1);
    check("lw_regrant", 32'(vga_rd_gnt), 32'd1);
    check("lw_level", 32'(fifo_level), 32'd1);
    idle(3);

    // Reset with three queued writes and a read in flight.
    drive(1'b0, 1'b1, 15'h0200, 16'hC000, 1'b1, 15'h0080);
    drive(1'b0, 1'b1, 15'h0201, 16'hC001, 1'b1, 15'h0080);
    drive(1'b0, 1'b1, 15'h0202, 16'hC002, 1'b1, 15'h0080);
    check("pre_rst_gnt", 32'(vga_rd_gnt), 32'd1);
    drive(1'b1, 1'b1, 15'h0203, 16'hC003, 1'b1, 15'h0080);
    check("in_rst_level", 32'(fifo_level), 32'd3);
    check("in_rst_valid", 32'(vga_rd_valid), 32'd0);
    check("in_rst_wr_en", 32'(mem_wr_en), 32'd0);
    idle(1);
    check("post_rst_level", 32'(fifo_level), 32'd0);
    check("post_rst_valid", 32'(vga_rd_valid), 32'd0);
    check("post_rst_wr_en", 32'(mem_wr_en), 32'd0);
    idle(2);

    // Randomized traffic over a small address window to exercise forwarding.
    hold = 1'b0;
    rq   = 1'b0;
    ra   = '0;
    for (int k = 0; k < 3000; k++) begin
      logic r;
      logic w;
      wr_pct = pct_tab[(k / 500) % 4][0];
      rd_pct = pct_tab[(k / 500) % 4][1];
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 99) < wr_pct);
      if (!hold) begin
        rq = ($urandom_range(0, 99) < rd_pct);
        ra = 15'($urandom_range(0, 31));
      end
      drive(r, w, 15'($urandom_range(0, 31)), 16'($urandom), rq, ra);
      hold = rq && !vga_rd_gnt && !r;
    end
    idle(8);
    check("final_level", 32'(fifo_level), 32'd0);

    for (int a = 0; a < 15'h0300; a++) check("mem_image", 32'(mem[a]), 32'(gold[a]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Clock  in  1  single clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 CpuWrEn  in  1  CPU data-memory write strobe; one write per asserted cycle; never stalled.
REQ-004 CpuAddr  in  15  CPU write address.
REQ-005 CpuData  in  16  CPU write data.
REQ-006 VgaRdReq  in  1  VGA read request; held until VgaRdGnt.
REQ-007 VgaRdAddr  in  15  VGA read address; stable while VgaRdReq=1 and not granted.
REQ-008 VgaRdGnt  out  1  read accepted this cycle (combinational).
REQ-009 VgaRdValid  out  1  registered; VgaRdData valid this cycle.
REQ-010 VgaRdData  out  16  read data.
REQ-011 MemAddr  out  15  shared single-port memory address (combinational).
REQ-012 MemWrEn  out  1  shared memory write enable (combinational).
REQ-013 MemWrData  out  16  shared memory write data.
REQ-014 MemRdData  in  16  memory read data; 1-cycle latency after MemAddr.
REQ-015 FifoLevel  out  3  current write-FIFO occupancy, 0..4.

Function
REQ-016 CPU writes SHALL enter a 4-entry FIFO; push occurs in the same cycle as CpuWrEn=1; the entry is poppable from the next cycle (no bypass).
REQ-017 Per cycle the memory port SHALL perform exactly one of: pop+write (MemWrEn=1, MemAddr/MemWrData=FIFO head), granted read (MemWrEn=0, MemAddr=VgaRdAddr), or idle (MemWrEn=0, MemAddr=0).
REQ-018 Arbiter FSM states: ARB_RD_PRIO, ARB_WR_DRAIN.
REQ-019 In ARB_RD_PRIO: VgaRdReq=1 -> grant read; else FIFO non-empty -> pop.
REQ-020 In ARB_WR_DRAIN: pop every cycle while non-empty; VgaRdGnt=0.
REQ-021 ARB_RD_PRIO -> ARB_WR_DRAIN at the edge where the next occupancy >=3 (high water) or StarveCnt reaches 8.
REQ-022 ARB_WR_DRAIN -> ARB_RD_PRIO at the edge where the next occupancy <=1 (low water).
REQ-023 StarveCnt (4 bit) SHALL increment on each read grant with FIFO non-empty, clear on any pop, saturate at 8.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged; at occupancy 4 a pop is always scheduled, so a push is never lost.
REQ-025 A read granted in cycle N SHALL give VgaRdValid=1 in N+1 with data as in REQ-026; VgaRdValid=0 otherwise.
REQ-026 Read forwarding: if VgaRdAddr matches the same-cycle push or any FIFO entry at grant, VgaRdData SHALL equal the youngest match's data, captured at N; else MemRdData.
REQ-027 FIFO pointers SHALL wrap modulo 4; FifoLevel SHALL be derived from a separate count register, not from pointer difference alone.

Reset
REQ-028 During Reset: FIFO empty, FifoLevel=0, state=ARB_RD_PRIO, StarveCnt=0, VgaRdValid=0, VgaRdGnt=0, MemWrEn=0, MemAddr=0, VgaRdData=0.
REQ-029 CpuWrEn and VgaRdReq SHALL be ignored in any cycle with Reset=1; a read granted in the cycle before Reset asserts SHALL NOT produce VgaRdValid.
REQ-030 Pending FIFO writes at Reset SHALL be discarded.

Structure
REQ-031 Shared package SHALL hold t_arb_state enum, ARB_FIFO_DEPTH=4, ARB_HIGH_WATER=3, ARB_LOW_WATER=1, ARB_STARVE_MAX=8.
REQ-032 FIFO storage, pointers, count and address-match logic SHALL live in sub-module dmem_wr_fifo; FSM, StarveCnt and muxing in the top.

Verification
REQ-033 Reset, then single push (0x0010, 0x1234), no reads -> MemWrEn=1, MemAddr=0x0010, MemWrData=0x1234 exactly one cycle later; FifoLevel 1 -> 0.
REQ-034 VgaRdReq with VgaRdAddr=0x0020 (mem holds 0xBEEF), FIFO empty -> VgaRdGnt same cycle, VgaRdValid=1, VgaRdData=0xBEEF next cycle.
REQ-035 CpuWrEn every cycle, VgaRdReq constant -> FifoLevel never exceeds 4, state enters ARB_WR_DRAIN at occupancy 3, returns at <=1, no write lost (memory image compared).
REQ-036 Two pushes to 0x0030 (0x1111, then 0x2222) still queued, read 0x0030 -> VgaRdData=0x2222.
REQ-037 FIFO occupancy 1 held by one push, VgaRdReq continuous -> after 8 consecutive grants, VgaRdGnt=0 and pop occurs on next cycle.
REQ-038 Reset asserted with FIFO occupancy 3 and a read granted previous cycle -> next cycle FifoLevel=0, VgaRdValid=0, MemWrEn=0; no queued writes reach memory.
